dmem_port_arbiter: RTL and testbench

- Shares the single byte-addressed data memory port between the two load/store lanes of the dual-issue pipe.
- Lane 0 is always the older instruction, so it has fixed priority.
- Sequences one access per grant:
  - stores complete in the grant cycle;
  - loads wait one cycle for memory data, then return a formatted, sign/zero-extended 32-bit result to the requesting lane.
- Sits between the execute/memory stage lanes and the data memory.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_load_format.sv | 26 ++
 rtl/dmem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory port arbiter.
// Memory words are big-endian on the bus (bits [31:24] = lowest byte
// address) while the pipeline works with little-endian values, so every
// path that crosses the port goes through byte_swap().
package dmem_pkg;

    // Access size encodings; 2'b11 is treated as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte enables; bit 3 is the byte at the access address.
    localparam logic [3:0] BE_BYTE = 4'b1000;
    localparam logic [3:0] BE_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

    // Converts between the little-endian lane value and the bus byte order.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [3:0] be_for_size(input logic [1:0] size);
        case (size)
            SZ_BYTE: return BE_BYTE;
            SZ_HALF: return BE_HALF;
            default: return BE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_format.sv
// Turns a raw memory word into a lane load result: byte-swap to a
// little-endian value, pick the low byte/half/word, then extend to 32 bits.
module dmem_load_format
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] v;

    assign v = byte_swap(raw);

    // Size select with sign or zero extension.
    always_comb begin
        result = v;
        case (size)
            SZ_BYTE: result = {{24{~is_unsigned & v[7]}},  v[7:0]};
            SZ_HALF: result = {{16{~is_unsigned & v[15]}}, v[15:0]};
            default: result = v;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the two load/store lanes.
// Lane 0 holds the older instruction and always wins. Stores finish in the
// grant cycle; loads spend one cycle in LOAD_WAIT collecting the memory data
// and return a formatted result two cycles after acceptance.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic              req0_we_i,
    input  logic [1:0]        req0_size_i,
    input  logic              req0_unsigned_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_data_o,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic              req1_we_i,
    input  logic [1:0]        req1_size_i,
    input  logic              req1_unsigned_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_data_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_t state_q, state_d;

    logic              in_idle;
    logic              grant0, grant1, grant_any;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_unsigned;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              load_accept;

    logic              lat_lane_q;
    logic [1:0]        lat_size_q;
    logic              lat_unsigned_q;
    logic [DATA_W-1:0] load_result;

    // Grants are only issued from IDLE and are suppressed while reset is
    // held, so every output reads 0 during reset.
    assign in_idle   = (state_q == ST_IDLE) && !reset_i;
    assign grant0    = in_idle && req0_valid_i;
    assign grant1    = in_idle && !req0_valid_i && req1_valid_i;
    assign grant_any = grant0 || grant1;

    assign sel_we       = grant1 ? req1_we_i       : req0_we_i;
    assign sel_size     = grant1 ? req1_size_i     : req0_size_i;
    assign sel_unsigned = grant1 ? req1_unsigned_i : req0_unsigned_i;
    assign sel_addr     = grant1 ? req1_addr_i     : req0_addr_i;
    assign sel_wdata    = grant1 ? req1_wdata_i    : req0_wdata_i;

    assign load_accept = grant_any && !sel_we;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: a granted load waits one cycle for memory data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (load_accept) state_d = ST_LOAD_WAIT;
            ST_LOAD_WAIT: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Outputs: ready for the granted lane and the memory command it drives.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        req0_ready_o = grant0;
        req1_ready_o = grant1;
        mem_addr_o   = '0;
        mem_re_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_wdata_o  = '0;
        if (grant_any) begin
            mem_addr_o = sel_addr;
            if (sel_we) begin
                mem_we_o    = 1'b1;
                mem_be_o    = be_for_size(sel_size);
                mem_wdata_o = byte_swap(sel_wdata);
            end else begin
                mem_re_o = 1'b1;
            end
        end
    end

    // Capture which lane owns the pending load and how to format it.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lat_lane_q     <= 1'b0;
            lat_size_q     <= SZ_BYTE;
            lat_unsigned_q <= 1'b0;
        end else if (load_accept) begin
            lat_lane_q     <= grant1;
            lat_size_q     <= sel_size;
            lat_unsigned_q <= sel_unsigned;
        end
    end

    dmem_load_format u_load_format (
        .raw         (mem_rdata_i),
        .size        (lat_size_q),
        .is_unsigned (lat_unsigned_q),
        .result      (load_result)
    );

    // Register the load result to the owning lane; data holds between loads.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rsp0_valid_o <= 1'b0;
            rsp1_valid_o <= 1'b0;
            rsp0_data_o  <= '0;
            rsp1_data_o  <= '0;
        end else begin
            rsp0_valid_o <= 1'b0;
            rsp1_valid_o <= 1'b0;
            if (state_q == ST_LOAD_WAIT) begin
                if (lat_lane_q) begin
                    rsp1_valid_o <= 1'b1;
                    rsp1_data_o  <= load_result;
                end else begin
                    rsp0_valid_o <= 1'b1;
                    rsp0_data_o  <= load_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter. Load responses are checked by a
// scoreboard monitor; grant and memory-command timing by directed checks.
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

    localparam int AW = 10;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          req0_valid_i, req0_ready_o, req0_we_i, req0_unsigned_i;
    logic [1:0]    req0_size_i;
    logic [AW-1:0] req0_addr_i;
    logic [31:0]   req0_wdata_i;
    logic          rsp0_valid_o;
    logic [31:0]   rsp0_data_o;
    logic          req1_valid_i, req1_ready_o, req1_we_i, req1_unsigned_i;
    logic [1:0]    req1_size_i;
    logic [AW-1:0] req1_addr_i;
    logic [31:0]   req1_wdata_i;
    logic          rsp1_valid_o;
    logic [31:0]   rsp1_data_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_re_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i = '0;

    always #5 clock_i = ~clock_i;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
        .req0_size_i(req0_size_i), .req0_unsigned_i(req0_unsigned_i), .req0_addr_i(req0_addr_i),
        .req0_wdata_i(req0_wdata_i), .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
        .req1_size_i(req1_size_i), .req1_unsigned_i(req1_unsigned_i), .req1_addr_i(req1_addr_i),
        .req1_wdata_i(req1_wdata_i), .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o),
        .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Byte-addressed memory model, wrapping modulo 2^AW, one-cycle read.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clock_i) begin
        if (mem_we_o)
            for (int k = 0; k < 4; k++)
                if (mem_be_o[3-k]) mem[AW'(mem_addr_o + k)] <= mem_wdata_o[31-8*k -: 8];
        if (mem_re_o)
            mem_rdata_i <= {mem[mem_addr_o], mem[AW'(mem_addr_o + 1)],
                            mem[AW'(mem_addr_o + 2)], mem[AW'(mem_addr_o + 3)]};
    end

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          lane;
        logic [31:0] data;
        int          at_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic expect_rsp(input int lane, input logic [31:0] data, input int at_cyc);
        exp_t e;
        e.lane   = lane;
        e.data   = data;
        e.at_cyc = at_cyc;
        sb.push_back(e);
    endtask

    // Response monitor: every pulse must match the oldest pending expectation.
    always @(negedge clock_i) begin
        if (rsp0_valid_o || rsp1_valid_o) begin
            check("rsp_one_lane", 32'(rsp0_valid_o & rsp1_valid_o), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: lane0=%0b lane1=%0b pulsed with nothing pending (cycle %0d)",
                         rsp0_valid_o, rsp1_valid_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_lane", rsp1_valid_o ? 32'd1 : 32'd0, 32'(mon_e.lane));
                check("rsp_data", rsp1_valid_o ? rsp1_data_o : rsp0_data_o, mon_e.data);
                check("rsp_cycle", 32'(cyc), 32'(mon_e.at_cyc));
            end
        end
    end

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic sample;
        @(negedge clock_i);
    endtask

    task automatic set_req(input int lane, input logic we, input logic [1:0] size, input logic uns,
                           input logic [AW-1:0] addr, input logic [31:0] wdata);
        if (lane == 0) begin
            req0_valid_i = 1'b1; req0_we_i = we; req0_size_i = size;
            req0_unsigned_i = uns; req0_addr_i = addr; req0_wdata_i = wdata;
        end else begin
            req1_valid_i = 1'b1; req1_we_i = we; req1_size_i = size;
            req1_unsigned_i = uns; req1_addr_i = addr; req1_wdata_i = wdata;
        end
    endtask

    task automatic drop(input int lane);
        if (lane == 0) req0_valid_i = 1'b0;
        else           req1_valid_i = 1'b0;
    endtask

    // One isolated load: accept at T, LOAD_WAIT at T+1, returns at T+2.
    task automatic run_load(input int lane, input logic [1:0] size, input logic uns,
                            input logic [AW-1:0] addr, input logic [31:0] exp);
        set_req(lane, 1'b0, size, uns, addr, 32'd0);
        sample;
        check("load_ready", lane == 0 ? 32'(req0_ready_o) : 32'(req1_ready_o), 32'd1);
        check("load_re", 32'(mem_re_o), 32'd1);
        check("load_addr", 32'(mem_addr_o), 32'(addr));
        expect_rsp(lane, exp, cyc + 2);
        tick;
        drop(lane);
        sample;
        check("wait_no_ready", 32'(req0_ready_o | req1_ready_o), 32'd0);
        check("wait_no_mem", 32'(mem_re_o | mem_we_o), 32'd0);
        tick;
    endtask

    // Back-to-back store table: address, size, value, expected bus data/enables.
    logic [AW-1:0] st_addr [4] = '{10'h100, 10'h104, 10'h108, 10'h200};
    logic [1:0]    st_size [4] = '{SZ_WORD, SZ_WORD, SZ_WORD, SZ_BYTE};
    logic [31:0]   st_data [4] = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'h123456A5};
    logic [31:0]   st_bus  [4] = '{32'h010000A0, 32'h020000B0, 32'h030000C0, 32'hA5563412};
    logic [3:0]    st_be   [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b1000};

    initial begin
        reset_i = 1'b1;
        req0_valid_i = 0; req0_we_i = 0; req0_size_i = 0; req0_unsigned_i = 0;
        req0_addr_i = 0; req0_wdata_i = 0;
        req1_valid_i = 0; req1_we_i = 0; req1_size_i = 0; req1_unsigned_i = 0;
        req1_addr_i = 0; req1_wdata_i = 0;
        tick;
        tick;
        sample;
        check("reset_ready", {30'd0, req0_ready_o, req1_ready_o}, 32'd0);
        check("reset_rsp_valid", {30'd0, rsp0_valid_o, rsp1_valid_o}, 32'd0);
        check("reset_rsp0_data", rsp0_data_o, 32'd0);
        check("reset_rsp1_data", rsp1_data_o, 32'd0);
        check("reset_mem_ctl", {26'd0, mem_re_o, mem_we_o, mem_be_o}, 32'd0);
        check("reset_mem_addr", 32'(mem_addr_o), 32'd0);
        check("reset_mem_wdata", mem_wdata_o, 32'd0);
        tick;
        reset_i = 1'b0;

        // Seed 0x010=0x80, 0x011=0x7F with a half store of value 0x7F80.
        set_req(0, 1'b1, SZ_HALF, 1'b0, 10'h010, 32'h00007F80);
        sample;
        check("seed_ready", 32'(req0_ready_o), 32'd1);
        check("seed_we", {30'd0, mem_we_o, mem_re_o}, 32'd2);
        check("seed_be", 32'(mem_be_o), 32'hC);
        check("seed_wdata", mem_wdata_o, 32'h807F0000);
        tick;
        drop(0);

        // Byte 0x80 signed/unsigned; half 0x7F80 has bit 15 clear, so it stays positive.
        run_load(0, SZ_BYTE, 1'b0, 10'h010, 32'hFFFFFF80);
        run_load(0, SZ_BYTE, 1'b1, 10'h010, 32'h00000080);
        run_load(0, SZ_HALF, 1'b0, 10'h010, 32'h00007F80);

        // Same cycle: lane 0 stores, lane 1 loads the same word.
        set_req(0, 1'b1, SZ_WORD, 1'b0, 10'h020, 32'h11223344);
        set_req(1, 1'b0, SZ_WORD, 1'b0, 10'h020, 32'd0);
        sample;
        check("pri_ready0", 32'(req0_ready_o), 32'd1);
        check("pri_ready1", 32'(req1_ready_o), 32'd0);
        check("pri_we", {30'd0, mem_we_o, mem_re_o}, 32'd2);
        check("pri_be", 32'(mem_be_o), 32'hF);
        check("pri_wdata", mem_wdata_o, 32'h44332211);
        check("pri_addr", 32'(mem_addr_o), 32'h020);
        expect_rsp(1, 32'h11223344, cyc + 3);
        tick;
        drop(0);
        sample;
        check("pri_ready1_next", 32'(req1_ready_o), 32'd1);
        check("pri_re", 32'(mem_re_o), 32'd1);
        tick;
        drop(1);
        tick;

        // Wrapping half store from lane 1, then read back.
        set_req(1, 1'b1, SZ_HALF, 1'b0, 10'h3FF, 32'h0000BEEF);
        sample;
        check("wrap_ready1", 32'(req1_ready_o), 32'd1);
        check("wrap_be", 32'(mem_be_o), 32'hC);
        check("wrap_wdata_hi", 32'(mem_wdata_o[31:16]), 32'hEFBE);
        check("wrap_addr", 32'(mem_addr_o), 32'h3FF);
        tick;
        drop(1);
        run_load(1, SZ_HALF, 1'b1, 10'h3FF, 32'h0000BEEF);
        run_load(0, SZ_HALF, 1'b0, 10'h3FF, 32'hFFFFBEEF);
        run_load(0, SZ_BYTE, 1'b1, 10'h000, 32'h000000BE);

        // Four back-to-back lane 0 stores, one per cycle.
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, st_size[i], 1'b0, st_addr[i], st_data[i]);
            sample;
            check("b2b_ready0", 32'(req0_ready_o), 32'd1);
            check("b2b_we", {30'd0, mem_we_o, mem_re_o}, 32'd2);
            check("b2b_be", 32'(mem_be_o), 32'(st_be[i]));
            check("b2b_wdata", mem_wdata_o, st_bus[i]);
            tick;
        end
        drop(0);
        run_load(0, SZ_BYTE, 1'b0, 10'h200, 32'hFFFFFFA5);
        run_load(1, 2'b11,   1'b0, 10'h108, 32'hC0000003);

        // Lane 0 load while lane 1 holds a load request.
        set_req(0, 1'b0, SZ_WORD, 1'b0, 10'h100, 32'd0);
        set_req(1, 1'b0, SZ_WORD, 1'b0, 10'h104, 32'd0);
        sample;
        check("hold_ready0_T", 32'(req0_ready_o), 32'd1);
        check("hold_ready1_T", 32'(req1_ready_o), 32'd0);
        expect_rsp(0, 32'hA0000001, cyc + 2);
        tick;
        drop(0);
        sample;
        check("hold_ready1_T1", 32'(req1_ready_o), 32'd0);
        tick;
        sample;
        check("hold_ready1_T2", 32'(req1_ready_o), 32'd1);
        expect_rsp(1, 32'hB0000002, cyc + 2);
        tick;
        drop(1);
        tick;
        sample;
        check("rsp0_data_held", rsp0_data_o, 32'hA0000001);
        tick;

        // Reset during LOAD_WAIT aborts the load.
        set_req(0, 1'b0, SZ_BYTE, 1'b0, 10'h010, 32'd0);
        sample;
        check("abort_ready0", 32'(req0_ready_o), 32'd1);
        tick;
        drop(0);
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        set_req(1, 1'b0, SZ_BYTE, 1'b1, 10'h011, 32'd0);
        sample;
        check("abort_rsp0_valid", 32'(rsp0_valid_o), 32'd0);
        check("abort_rsp0_data", rsp0_data_o, 32'd0);
        check("abort_rsp1_data", rsp1_data_o, 32'd0);
        check("abort_regrant", 32'(req1_ready_o), 32'd1);
        expect_rsp(1, 32'h0000007F, cyc + 2);
        tick;
        drop(1);

        repeat (4) tick;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
